// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle for uart_baud_gen_frac.
//   master : drives en, sync, div_int, div_frac, div_wr; observes the tick outputs
//   slave  : the baud generator itself
// Signals:
//   en           generator enable
//   sync         realign pulse (restart prescaler and bit phase)
//   div_int      integer clocks per oversample tick
//   div_frac     fractional clocks per oversample tick (unit 1/2^FRAC_W)
//   div_wr       one-cycle strobe capturing div_int/div_frac into the shadow
//   cfg_pending  shadow written but not yet active
//   baud_tick_os one-cycle oversample tick
//   baud_tick    one-cycle bit tick (coincident with last os tick of the bit)
//   os_phase     index of the current os period within the bit
interface uart_baud_gen_frac_if #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
);
  localparam int unsigned PhaseW = $clog2(OVERSAMPLE);

  logic              en;
  logic              sync;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_wr;
  logic              cfg_pending;
  logic              baud_tick_os;
  logic              baud_tick;
  logic [PhaseW-1:0] os_phase;

  modport master (
    output en, sync, div_int, div_frac, div_wr,
    input  cfg_pending, baud_tick_os, baud_tick, os_phase
  );

  modport slave (
    input  en, sync, div_int, div_frac, div_wr,
    output cfg_pending, baud_tick_os, baud_tick, os_phase
  );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Runtime-programmable UART baud generator with fractional divisor and oversampling.
// Produces a one-cycle oversample tick every P clocks, where P = div_int plus the carry of a
// fractional accumulator, and a one-cycle bit tick on the last oversample tick of each bit.
// Divisor writes land in a shadow register and become active on the next period start, or
// immediately on the next cycle while disabled / resynchronising.
//
// Build option: define UART_BAUD_FRAC_EN to enable the fractional accumulator. Without it,
// div_frac is ignored and P = div_int.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-low reset
//   bus  uart_baud_gen_frac_if.slave (en, sync, div_int, div_frac, div_wr in;
//        cfg_pending, baud_tick_os, baud_tick, os_phase out)
module uart_baud_gen_frac #(
  parameter int unsigned CLOCK_FREQ = 1_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input logic                 clk,
  input logic                 rst,
  uart_baud_gen_frac_if.slave bus
);
  localparam int unsigned PhaseW = $clog2(OVERSAMPLE);
  localparam int unsigned PerW   = DIV_W + 1;

  // Reset-default divisor, rounded to the nearest 1/2^FRAC_W.
  localparam longint unsigned DefX =
      ((longint'(CLOCK_FREQ) * (longint'(1) << (FRAC_W + 1))) /
       (longint'(BAUD_RATE) * longint'(OVERSAMPLE)) + 1) / 2;
  localparam logic [DIV_W-1:0] DefInt = DIV_W'(DefX >> FRAC_W);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [PerW-1:0]   per_q, per_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [DIV_W-1:0]  shd_int_q, shd_int_d;
  logic              pend_q, pend_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_q, tick_d;

  logic              run;
  logic              period_start;
  logic              apply;
  logic              wr_ok;
  logic [DIV_W-1:0]  eff_int;
  logic [PerW-1:0]   p_new;
  logic [PerW-1:0]   p_cur;
  logic              os_done;

  // sync behaves like a one-cycle disable: counters cleared, no tick.
  assign run          = bus.en & ~bus.sync;
  assign period_start = (cnt_q == '0);
  assign apply        = pend_q & (~run | period_start);
  assign wr_ok        = bus.div_wr & (bus.div_int != '0);
  assign eff_int      = apply ? shd_int_q : act_int_q;

`ifdef UART_BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] DefFrac = FRAC_W'(DefX);

  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] eff_frac;
  logic [FRAC_W:0]   acc_sum;

  assign eff_frac = apply ? shd_frac_q : act_frac_q;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, eff_frac};
  assign p_new    = {1'b0, eff_int} + PerW'(acc_sum[FRAC_W]);

  always_comb begin
    act_frac_d = act_frac_q;
    shd_frac_d = shd_frac_q;
    acc_d      = acc_q;
    if (apply) act_frac_d = shd_frac_q;
    if (wr_ok) shd_frac_d = bus.div_frac;
    if (!run) begin
      acc_d = '0;
    end else if (period_start) begin
      acc_d = acc_sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      act_frac_q <= DefFrac;
      shd_frac_q <= DefFrac;
      acc_q      <= '0;
    end else begin
      act_frac_q <= act_frac_d;
      shd_frac_q <= shd_frac_d;
      acc_q      <= acc_d;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^bus.div_frac;
  assign p_new       = {1'b0, eff_int};
`endif

  // Period length is latched at period start; P==1 relies on the bypass path every cycle.
  assign p_cur   = period_start ? p_new : per_q;
  assign os_done = ({1'b0, cnt_q} == (p_cur - PerW'(1)));

  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    phase_d   = phase_q;
    act_int_d = act_int_q;
    shd_int_d = shd_int_q;
    pend_d    = pend_q;
    tick_os_d = 1'b0;
    tick_d    = 1'b0;

    if (apply) begin
      act_int_d = shd_int_q;
      pend_d    = 1'b0;
    end
    // A write in the same cycle as an apply still re-arms the shadow for the next boundary.
    if (wr_ok) begin
      shd_int_d = bus.div_int;
      pend_d    = 1'b1;
    end

    if (!run) begin
      cnt_d   = '0;
      phase_d = '0;
    end else begin
      if (period_start) per_d = p_new;
      if (os_done) begin
        cnt_d     = '0;
        tick_os_d = 1'b1;
        tick_d    = (phase_q == PhaseW'(OVERSAMPLE - 1));
        phase_d   = phase_q + PhaseW'(1);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      per_q     <= '0;
      phase_q   <= '0;
      act_int_q <= DefInt;
      shd_int_q <= DefInt;
      pend_q    <= 1'b0;
      tick_os_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      phase_q   <= phase_d;
      act_int_q <= act_int_d;
      shd_int_q <= shd_int_d;
      pend_q    <= pend_d;
      tick_os_q <= tick_os_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.cfg_pending  = pend_q;
  assign bus.baud_tick_os = tick_os_q;
  assign bus.baud_tick    = tick_q;
  assign bus.os_phase     = phase_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
module tb_uart_baud_gen_frac;
  localparam int unsigned OS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_baud_gen_frac_if #(.OVERSAMPLE(OS), .DIV_W(16), .FRAC_W(4)) bus ();

  uart_baud_gen_frac #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (9600),
    .OVERSAMPLE(OS),
    .DIV_W     (16),
    .FRAC_W    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] di;
    logic [3:0]  df;
  } vec_t;

  vec_t vecs[6];
  int   exp_gap_q[$];
  int   exp_ph_q[$];
  bit   exp_bt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count negedges until baud_tick_os is seen; bounded so a dead DUT still terminates.
  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (bus.baud_tick_os !== 1'b1 && gap < 2000);
  endtask

  task automatic program_div(input logic [15:0] di, input logic [3:0] df);
    @(negedge clk);
    bus.en       = 1'b0;
    bus.div_int  = di;
    bus.div_frac = df;
    bus.div_wr   = 1'b1;
    @(negedge clk);
    bus.div_wr = 1'b0;
    check("pending after write", 32'(bus.cfg_pending), 1);
    @(negedge clk);
    check("pending applied while disabled", 32'(bus.cfg_pending), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int acc;
    int s;
    int p;
    int ph;

    rst          = 1'b0;
    bus.en       = 1'b1;
    bus.sync     = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.div_wr   = 1'b0;

    // T1: outputs quiet in reset, then default divisor (6 + 8/16).
    repeat (4) begin
      @(negedge clk);
      check("reset outputs",
            32'({bus.cfg_pending, bus.baud_tick_os, bus.baud_tick, bus.os_phase}), 0);
    end
    rst = 1'b1;
    wait_tick(g);
    check("T1 first gap after reset", 32'(g), 6);
    wait_tick(g);
`ifdef UART_BAUD_FRAC_EN
    check("T1 second gap (frac carry)", 32'(g), 7);
`else
    check("T1 second gap", 32'(g), 6);
`endif

    // Table: one full bit per divisor setting, expected gaps queued before enabling.
    vecs[0] = '{16'd4, 4'd0};
    vecs[1] = '{16'd4, 4'd8};
    vecs[2] = '{16'd1, 4'd0};
    vecs[3] = '{16'd3, 4'd5};
    vecs[4] = '{16'd7, 4'd15};
    vecs[5] = '{16'd2, 4'd1};

    for (int i = 0; i < 6; i++) begin
      program_div(vecs[i].di, vecs[i].df);
      acc = 0;
      for (int k = 0; k < OS; k++) begin
`ifdef UART_BAUD_FRAC_EN
        s   = acc + int'(vecs[i].df);
        p   = int'(vecs[i].di) + (s >> 4);
        acc = s & 15;
`else
        p = int'(vecs[i].di);
`endif
        exp_gap_q.push_back(p);
        exp_bt_q.push_back(k == OS - 1);
        exp_ph_q.push_back((k + 1) % OS);
      end
      bus.en = 1'b1;
      while (exp_gap_q.size() > 0) begin
        wait_tick(g);
        check($sformatf("vec%0d os gap", i), 32'(g), 32'(exp_gap_q.pop_front()));
        check($sformatf("vec%0d baud_tick", i), 32'(bus.baud_tick), 32'(exp_bt_q.pop_front()));
        check($sformatf("vec%0d os_phase", i), 32'(bus.os_phase), 32'(exp_ph_q.pop_front()));
      end
    end

    // T4: write 8 mid-period of divisor 4; old period completes, then 8-clock periods.
    program_div(16'd4, 4'd0);
    bus.en = 1'b1;
    wait_tick(g);
    check("T4 base gap", 32'(g), 4);
    @(negedge clk);
    bus.div_int = 16'd8;
    bus.div_wr  = 1'b1;
    @(negedge clk);
    bus.div_wr = 1'b0;
    check("T4 pending mid-period", 32'(bus.cfg_pending), 1);
    wait_tick(g);
    check("T4 remainder of old period", 32'(g), 2);
    check("T4 pending at boundary tick", 32'(bus.cfg_pending), 1);
    wait_tick(g);
    check("T4 first new period", 32'(g), 8);
    check("T4 pending cleared", 32'(bus.cfg_pending), 0);
    wait_tick(g);
    check("T4 second new period", 32'(g), 8);

    // T5: sync mid-period at os_phase 7.
    ph = 0;
    for (int n = 0; n < 20; n++) begin
      wait_tick(g);
      ph = int'(bus.os_phase);
      if (ph == 7) break;
    end
    check("T5 reached os_phase 7", 32'(ph), 7);
    repeat (3) @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    check("T5 no tick on sync", 32'(bus.baud_tick_os), 0);
    check("T5 os_phase cleared", 32'(bus.os_phase), 0);
    wait_tick(g);
    check("T5 gap after sync", 32'(g), 8);
    check("T5 os_phase after first tick", 32'(bus.os_phase), 1);

    // T5b: sync coincident with the cycle that would produce a tick.
    repeat (7) @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    check("T5b coincident tick suppressed", 32'(bus.baud_tick_os), 0);
    check("T5b os_phase cleared", 32'(bus.os_phase), 0);
    wait_tick(g);
    check("T5b gap after sync", 32'(g), 8);

    // T6: div_int==0 write ignored; then disable mid-bit.
    @(negedge clk);
    bus.div_int = 16'd0;
    bus.div_wr  = 1'b1;
    @(negedge clk);
    bus.div_wr = 1'b0;
    check("T6 zero write not pending", 32'(bus.cfg_pending), 0);
    wait_tick(g);
    check("T6 period in progress", 32'(g), 6);
    wait_tick(g);
    check("T6 period unchanged", 32'(g), 8);
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("T6 disabled no tick", 32'(bus.baud_tick_os), 0);
      check("T6 disabled os_phase", 32'(bus.os_phase), 0);
    end
    bus.en = 1'b1;
    wait_tick(g);
    check("T6 gap after re-enable", 32'(g), 8);
    check("T6 os_phase after re-enable", 32'(bus.os_phase), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
